// File: rtl/control_turno_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: FSM states, result
// codes, player codes and the eight winning-line masks.
package control_turno_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'b00,
        ESCRIBE = 2'b01,
        EVALUA  = 2'b10,
        FIN     = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        NINGUNO = 2'b00,
        GANA_X  = 2'b01,
        GANA_O  = 2'b10,
        EMPATE  = 2'b11
    } ganador_t;

    localparam logic JUG_X = 1'b0;
    localparam logic JUG_O = 1'b1;

    localparam int unsigned NUM_LINEAS = 8;

    // Bit i of each mask is cell i (row-major).
    localparam logic [NUM_LINEAS-1:0][8:0] LINEAS = {
        9'h054,  // 2,4,6
        9'h111,  // 0,4,8
        9'h124,  // 2,5,8
        9'h092,  // 1,4,7
        9'h049,  // 0,3,6
        9'h1C0,  // 6,7,8
        9'h038,  // 3,4,5
        9'h007   // 0,1,2
    };

    // One-hot cell mask; all zeros for positions outside the board.
    function automatic logic [8:0] mascara_celda(input logic [3:0] pos);
        return (pos <= 4'd8) ? (9'b1 << pos) : '0;
    endfunction

endpackage

// File: rtl/control_turno_detector_linea.sv
// Combinational check: is any of the eight winning lines fully occupied on
// the given board?
module detector_linea
    import control_turno_pkg::*;
(
    input  logic [8:0] tablero,
    output logic       hay_linea
);

    always_comb begin
        hay_linea = 1'b0;
        for (int unsigned i = 0; i < NUM_LINEAS; i++) begin
            if ((tablero & LINEAS[i]) == LINEAS[i]) begin
                hay_linea = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_turno.sv
// Turn controller: validates move requests, writes the board, detects a win
// or draw and alternates the current player. All outputs are registered.
module control_turno
    import control_turno_pkg::*;
#(
    parameter logic JUGADOR_INICIAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       solicitud,
    input  logic [3:0] posicion,
    input  logic       reiniciar,
    output logic       jugador,
    output logic [8:0] tablero_x,
    output logic [8:0] tablero_o,
    output logic       ack,
    output logic       rechazo,
    output logic [1:0] ganador,
    output logic       fin_juego
);

    estado_t    estado_q, estado_d;
    ganador_t   ganador_q, ganador_d;
    logic [3:0] pos_q, pos_d;
    logic       jugador_q, jugador_d;
    logic [8:0] tx_q, tx_d;
    logic [8:0] to_q, to_d;
    logic       ack_q, ack_d;
    logic       rech_q, rech_d;
    logic       fin_q, fin_d;

    logic [8:0] mascara;
    logic [8:0] ocupadas;
    logic       hay_linea;

    assign ocupadas = tx_q | to_q;
    assign mascara  = mascara_celda(posicion);

    detector_linea u_detector (
        .tablero   (jugador_q == JUG_O ? to_q : tx_q),
        .hay_linea (hay_linea)
    );

    always_comb begin
        estado_d  = estado_q;
        ganador_d = ganador_q;
        pos_d     = pos_q;
        jugador_d = jugador_q;
        tx_d      = tx_q;
        to_d      = to_q;
        fin_d     = fin_q;
        ack_d     = 1'b0;
        rech_d    = 1'b0;

        if (reiniciar) begin
            estado_d  = ESPERA;
            ganador_d = NINGUNO;
            pos_d     = '0;
            jugador_d = JUGADOR_INICIAL;
            tx_d      = '0;
            to_d      = '0;
            fin_d     = 1'b0;
        end else begin
            unique case (estado_q)
                ESPERA: begin
                    if (solicitud) begin
                        if (mascara == '0 || (mascara & ocupadas) != '0) begin
                            rech_d = 1'b1;
                        end else begin
                            pos_d    = posicion;
                            estado_d = ESCRIBE;
                        end
                    end
                end
                ESCRIBE: begin
                    if (jugador_q == JUG_O) to_d = to_q | mascara_celda(pos_q);
                    else                    tx_d = tx_q | mascara_celda(pos_q);
                    estado_d = EVALUA;
                end
                EVALUA: begin
                    if (hay_linea) begin
                        ganador_d = (jugador_q == JUG_O) ? GANA_O : GANA_X;
                        fin_d     = 1'b1;
                        estado_d  = FIN;
                    end else if (&ocupadas) begin
                        ganador_d = EMPATE;
                        fin_d     = 1'b1;
                        estado_d  = FIN;
                    end else begin
                        jugador_d = ~jugador_q;
                        ack_d     = 1'b1;
                        estado_d  = ESPERA;
                    end
                end
                FIN: ;
                default: estado_d = ESPERA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= ESPERA;
            ganador_q <= NINGUNO;
            pos_q     <= '0;
            jugador_q <= JUGADOR_INICIAL;
            tx_q      <= '0;
            to_q      <= '0;
            ack_q     <= 1'b0;
            rech_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            ganador_q <= ganador_d;
            pos_q     <= pos_d;
            jugador_q <= jugador_d;
            tx_q      <= tx_d;
            to_q      <= to_d;
            ack_q     <= ack_d;
            rech_q    <= rech_d;
            fin_q     <= fin_d;
        end
    end

    assign jugador   = jugador_q;
    assign tablero_x = tx_q;
    assign tablero_o = to_q;
    assign ack       = ack_q;
    assign rechazo   = rech_q;
    assign ganador   = ganador_q;
    assign fin_juego = fin_q;

endmodule

// File: tb/tb_control_turno.sv
// Directed bench for control_turno: a small reference model pushes expected
// output snapshots to a queue, which are popped and compared after each edge.
module tb_control_turno;

    logic       clk = 1'b0;
    logic       reset, solicitud, reiniciar;
    logic [3:0] posicion;
    logic       jugador, ack, rechazo, fin_juego;
    logic [8:0] tablero_x, tablero_o;
    logic [1:0] ganador;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    typedef struct {
        string      tag;
        logic       ack;
        logic       rech;
        logic       jug;
        logic [8:0] x;
        logic [8:0] o;
        logic [1:0] g;
        logic       fin;
    } snap_t;

    snap_t sb[$];

    // Reference model state
    logic       mj;
    logic [8:0] mx, mo;
    logic [1:0] mg;
    logic       mfin;

    control_turno #(.JUGADOR_INICIAL(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .solicitud (solicitud),
        .posicion  (posicion),
        .reiniciar (reiniciar),
        .jugador   (jugador),
        .tablero_x (tablero_x),
        .tablero_o (tablero_o),
        .ack       (ack),
        .rechazo   (rechazo),
        .ganador   (ganador),
        .fin_juego (fin_juego)
    );

    always #5 clk = ~clk;

    function automatic logic gana(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic a, input logic r);
        snap_t s;
        s.tag = tag; s.ack = a; s.rech = r; s.jug = mj;
        s.x = mx; s.o = mo; s.g = mg; s.fin = mfin;
        sb.push_back(s);
    endtask

    task automatic chk();
        snap_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp({e.tag, "_ack"},     {8'd0, ack},       {8'd0, e.ack});
        cmp({e.tag, "_rechazo"}, {8'd0, rechazo},   {8'd0, e.rech});
        cmp({e.tag, "_jugador"}, {8'd0, jugador},   {8'd0, e.jug});
        cmp({e.tag, "_tx"},      tablero_x,         e.x);
        cmp({e.tag, "_to"},      tablero_o,         e.o);
        cmp({e.tag, "_ganador"}, {7'd0, ganador},   {7'd0, e.g});
        cmp({e.tag, "_fin"},     {8'd0, fin_juego}, {8'd0, e.fin});
        cmp({e.tag, "_excl"},    tablero_x & tablero_o, 9'd0);
        cmp({e.tag, "_ackrech"}, {8'd0, ack & rechazo}, 9'd0);
    endtask

    task automatic model_clear();
        mj = 1'b0; mx = '0; mo = '0; mg = 2'b00; mfin = 1'b0;
    endtask

    task automatic restart(input string tag);
        reiniciar = 1'b1;
        model_clear();
        push(tag, 1'b0, 1'b0);
        chk();
        reiniciar = 1'b0;
    endtask

    // Full move request: one cycle of solicitud, then wait out the outcome.
    task automatic mover(input logic [3:0] p, input string tag);
        logic [8:0] cel;
        logic       libre;
        cel   = (p <= 4'd8) ? (9'b1 << p) : 9'd0;
        libre = (cel != 9'd0) && ((cel & (mx | mo)) == 9'd0);
        solicitud = 1'b1;
        posicion  = p;
        if (mfin) begin
            push({tag, "_fin0"}, 1'b0, 1'b0);
            chk();
            solicitud = 1'b0;
            push({tag, "_fin1"}, 1'b0, 1'b0);
            chk();
        end else if (!libre) begin
            push({tag, "_rech"}, 1'b0, 1'b1);
            chk();
            solicitud = 1'b0;
            push({tag, "_rechoff"}, 1'b0, 1'b0);
            chk();
        end else begin
            push({tag, "_n0"}, 1'b0, 1'b0);
            chk();
            solicitud = 1'b0;
            if (mj) mo = mo | cel; else mx = mx | cel;
            push({tag, "_n1"}, 1'b0, 1'b0);
            chk();
            if (gana(mj ? mo : mx)) begin
                mg = mj ? 2'b10 : 2'b01; mfin = 1'b1;
                push({tag, "_n2"}, 1'b0, 1'b0);
            end else if (&(mx | mo)) begin
                mg = 2'b11; mfin = 1'b1;
                push({tag, "_n2"}, 1'b0, 1'b0);
            end else begin
                mj = ~mj;
                push({tag, "_n2"}, 1'b1, 1'b0);
            end
            chk();
            push({tag, "_n3"}, 1'b0, 1'b0);
            chk();
        end
    endtask

    initial begin
        reset = 1'b1; reiniciar = 1'b0; solicitud = 1'b0; posicion = '0;
        model_clear();
        push("reset", 1'b0, 1'b0);
        chk();
        reset = 1'b0;

        // First move to centre, then illegal repeats
        mover(4'd4, "x4");
        mover(4'd4, "o4_ocupada");
        mover(4'd9, "pos9");
        mover(4'd15, "pos15");

        // X wins on the top row; further requests ignored
        restart("rein1");
        mover(4'd0, "w_x0"); mover(4'd3, "w_o3"); mover(4'd1, "w_x1");
        mover(4'd4, "w_o4"); mover(4'd2, "w_x2");
        mover(4'd5, "w_tras_fin");
        push("fin_hold", 1'b0, 1'b0);
        chk();

        // O wins on the middle row, X uses corner 8
        restart("rein2");
        mover(4'd0, "o_x0"); mover(4'd3, "o_o3"); mover(4'd1, "o_x1");
        mover(4'd4, "o_o4"); mover(4'd8, "o_x8"); mover(4'd5, "o_o5");

        // Draw
        restart("rein3");
        mover(4'd0, "d_x0"); mover(4'd1, "d_o1"); mover(4'd2, "d_x2");
        mover(4'd4, "d_o4"); mover(4'd3, "d_x3"); mover(4'd5, "d_o5");
        mover(4'd7, "d_x7"); mover(4'd6, "d_o6"); mover(4'd8, "d_x8");

        // reiniciar during ESCRIBE discards the in-flight move
        restart("rein4");
        mover(4'd0, "e_x0");
        solicitud = 1'b1; posicion = 4'd6;
        push("e_req", 1'b0, 1'b0);
        chk();
        solicitud = 1'b0;
        reiniciar = 1'b1;
        model_clear();
        push("e_rein", 1'b0, 1'b0);
        chk();
        reiniciar = 1'b0;
        push("e_noack", 1'b0, 1'b0);
        chk();

        // reset + reiniciar + solicitud on an occupied cell
        mover(4'd4, "r_x4");
        reset = 1'b1; reiniciar = 1'b1; solicitud = 1'b1; posicion = 4'd4;
        model_clear();
        push("r_all", 1'b0, 1'b0);
        chk();
        reset = 1'b0; reiniciar = 1'b0; solicitud = 1'b0;
        push("r_after", 1'b0, 1'b0);
        chk();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
